// File: rtl/div_recon_mul.sv
// div_recon_mul: sequential shift-and-add multiply-accumulate, res = q*d + r.
// Rebuilds a 2*W-bit dividend from a divider's quotient, divisor and remainder.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   in_valid/ready   operand handshake; in_ready high only while idle
//   q, d, r          multiplier, multiplicand, addend (W bits each)
//   out_valid/ready  result handshake; res held stable while out_valid
//   res              q*d + r (2*W bits, unsigned)
//   busy             high while computing or holding a result
module div_recon_mul #(
    parameter int unsigned W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    q,
    input  logic [W-1:0]    d,
    input  logic [W-1:0]    r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0] res,
    output logic            busy
);

    localparam int unsigned RW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [RW-1:0] acc;
    logic [RW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] count;
    logic          accept_c;
    logic          last_c;
    logic [RW-1:0] acc_sum_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and step decode
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                // Always W iterations; no early exit when mplier runs out of ones
                if (count == CW'(W - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Partial-product accumulate for the current multiplier bit
    assign acc_sum_c = mplier[0] ? (acc + mcand) : acc;

    // Shift-and-add datapath; operands captured only at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (accept_c) begin
            acc    <= RW'(r);
            mcand  <= RW'(d);
            mplier <= q;
            count  <= '0;
        end else if (state == CALC) begin
            acc    <= acc_sum_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    // Result latched only on the final iteration, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res <= '0;
        end else if (last_c) begin
            res <= acc_sum_c;
        end
    end

    // Status flags registered from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_div_recon_mul.sv
// Self-checking bench for div_recon_mul: directed vectors plus a randomized
// scoreboard run with back-pressure.
module tb_div_recon_mul;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic        busy;

    int tests;
    int fails;

    div_recon_mul #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid with a bound; returns cycles waited
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // One operation with out_ready high; checks latency, result and return to idle
    task automatic do_op(input string tag, input logic [7:0] qq, input logic [7:0] dd,
                         input logic [7:0] rr, input logic [15:0] exp);
        int lat;
        q = qq; d = dd; r = rr;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_in_ready_calc"}, in_ready, 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            if (!out_valid) lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_res"}, res, exp);
        tick();
        check({tag, "_out_valid_drop"}, out_valid, 1'b0);
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
    endtask

    logic [15:0] sb[$];

    initial begin
        int lat;
        int rises;
        int n_in;
        int n_out;
        int cyc;
        logic [7:0] rq, rd, rr;
        logic [15:0] ex;

        tests = 0; fails = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q = '0; d = '0; r = '0;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res", res, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        tick();

        do_op("basic", 8'd17, 8'd12, 8'd5, 16'h00D1);
        do_op("max", 8'd255, 8'd255, 8'd254, 16'hFEFF);
        do_op("q_zero", 8'd0, 8'd200, 8'd7, 16'h0007);
        do_op("d_zero", 8'd1, 8'd0, 8'd0, 16'h0000);

        // Back-pressure: result held for 20 cycles, one transfer on one out_ready
        q = 8'd3; d = 8'd4; r = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_res", res, 16'h000D);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_xfer_drop", out_valid, 1'b0);
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) rises++;
        end
        check("bp_no_dup", rises, 0);
        check("bp_idle", in_ready, 1'b1);

        // in_valid held with changing operands during CALC and DONE
        q = 8'd10; d = 8'd10; r = 8'd3; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        q = 8'd200; d = 8'd100; r = 8'd50;
        wait_valid(lat);
        check("hold_first_valid", out_valid, 1'b1);
        check("hold_first_res", res, 16'd103);
        tick();
        tick();
        check("hold_first_stable", res, 16'd103);
        out_ready = 1'b1;
        tick();
        check("hold_back_idle", in_ready, 1'b1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("hold_second_accepted", busy, 1'b1);
        wait_valid(lat);
        check("hold_second_res", res, 16'd20050);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the 4th CALC cycle discards the operation
        q = 8'd9; d = 8'd9; r = 8'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_res", res, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) rises++;
        end
        check("mid_rst_no_valid", rises, 0);
        do_op("after_rst", 8'd2, 8'd3, 8'd1, 16'h0007);

        // Randomized scoreboard run with stalls on both sides
        n_in = 0; n_out = 0; cyc = 0;
        while (n_out < 500 && cyc < 20000) begin
            rq = 8'($urandom); rd = 8'($urandom); rr = 8'($urandom);
            q = rq; d = rd; r = rr;
            in_valid  = (n_in < 500) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                ex = 16'(int'(rq) * int'(rd) + int'(rr));
                sb.push_back(ex);
                n_in++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_unexpected_out", 1, 0);
                end else begin
                    check("rand_res", res, sb.pop_front());
                end
                n_out++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rand_count", n_out, 500);
        check("rand_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
